// File: rtl/clk_period_meter.sv
// clk_period_meter: measures high time, low time and period of an
// asynchronous slow square wave (SigIn) in ClkIn cycles.
// Single-shot Start/Valid/Ack handshake by default; define
// CLK_PERIOD_METER_CONTINUOUS_EN for free-running measurement with a
// one-cycle Valid pulse per completed period.
module clk_period_meter #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 16777215
) (
    input  logic             ClkIn,
    input  logic             rst,
    input  logic             SigIn,
    input  logic             Start,
    input  logic             Ack,
    output logic             Busy,
    output logic             Valid,
    output logic             TimeoutErr,
    output logic [CNT_W-1:0] HighTime,
    output logic [CNT_W-1:0] LowTime,
    output logic [CNT_W:0]   Period
);

    localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s_q, sd_q;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
    logic             valid_q, valid_d;
    logic             timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [CNT_W-1:0] low_time_q, low_time_d;
    logic [CNT_W:0]   period_q, period_d;

    logic             rise, fall, phase_expired;
    logic             lat_en, lat_to;
    logic [CNT_W-1:0] lat_hi, lat_lo;

    assign rise          = s_q & ~sd_q;
    assign fall          = ~s_q & sd_q;
    assign phase_expired = (phase_cnt_q == TIMEOUT_V);

`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
    // Free-running: handshake inputs have no function here.
    logic unused_handshake;
    assign unused_handshake = Start ^ Ack;
    assign Busy = (state_q != ST_IDLE);
`else
    assign Busy = (state_q == ST_SYNC) || (state_q == ST_HIGH) || (state_q == ST_LOW);
`endif

    // Next-state, counter and result computation.
    always_comb begin
        state_d       = state_q;
        hi_cnt_d      = hi_cnt_q;
        lo_cnt_d      = lo_cnt_q;
        phase_cnt_d   = phase_cnt_q;
        valid_d       = valid_q;
        timeout_err_d = timeout_err_q;
        high_time_d   = high_time_q;
        low_time_d    = low_time_q;
        period_d      = period_q;
        lat_en        = 1'b0;
        lat_to        = 1'b0;
        lat_hi        = CNT_ZERO;
        lat_lo        = CNT_ZERO;
`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
        valid_d       = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
                state_d     = ST_SYNC;
                phase_cnt_d = CNT_ZERO;
`else
                if (Start) begin
                    state_d     = ST_SYNC;
                    phase_cnt_d = CNT_ZERO;
                end
`endif
            end
            ST_SYNC: begin
                if (rise) begin
                    state_d     = ST_HIGH;
                    hi_cnt_d    = CNT_ONE;
                    phase_cnt_d = CNT_ONE;
                end else if (phase_expired) begin
                    lat_en = 1'b1;
                    lat_to = 1'b1;
                end else begin
                    phase_cnt_d = phase_cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d     = ST_LOW;
                    lo_cnt_d    = CNT_ONE;
                    phase_cnt_d = CNT_ONE;
                end else if (phase_expired) begin
                    lat_en = 1'b1;
                    lat_to = 1'b1;
                    lat_hi = hi_cnt_q;
                end else begin
                    hi_cnt_d    = hi_cnt_q + CNT_ONE;
                    phase_cnt_d = phase_cnt_q + CNT_ONE;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    lat_en = 1'b1;
                    lat_hi = hi_cnt_q;
                    lat_lo = lo_cnt_q;
                end else if (phase_expired) begin
                    lat_en = 1'b1;
                    lat_to = 1'b1;
                    lat_hi = hi_cnt_q;
                    lat_lo = lo_cnt_q;
                end else begin
                    lo_cnt_d    = lo_cnt_q + CNT_ONE;
                    phase_cnt_d = phase_cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
                state_d     = ST_SYNC;
                phase_cnt_d = CNT_ZERO;
`else
                // Start takes priority over Ack when both arrive together.
                if (Start) begin
                    state_d       = ST_SYNC;
                    phase_cnt_d   = CNT_ZERO;
                    valid_d       = 1'b0;
                    timeout_err_d = 1'b0;
                end else if (Ack) begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Result latch and end-of-measurement state selection.
        if (lat_en) begin
            high_time_d   = lat_hi;
            low_time_d    = lat_lo;
            period_d      = {1'b0, lat_hi} + {1'b0, lat_lo};
            valid_d       = 1'b1;
            timeout_err_d = lat_to;
`ifdef CLK_PERIOD_METER_CONTINUOUS_EN
            if (lat_to) begin
                state_d     = ST_SYNC;
                phase_cnt_d = CNT_ZERO;
            end else begin
                // The closing rise also opens the next high phase.
                state_d     = ST_HIGH;
                hi_cnt_d    = CNT_ONE;
                phase_cnt_d = CNT_ONE;
            end
`else
            state_d = ST_DONE;
`endif
        end
    end

    // State, synchronizer, counter and output registers.
    always_ff @(posedge ClkIn or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            s1_q          <= 1'b0;
            s_q           <= 1'b0;
            sd_q          <= 1'b0;
            hi_cnt_q      <= '0;
            lo_cnt_q      <= '0;
            phase_cnt_q   <= '0;
            valid_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            high_time_q   <= '0;
            low_time_q    <= '0;
            period_q      <= '0;
        end else begin
            state_q       <= state_d;
            s1_q          <= SigIn;
            s_q           <= s1_q;
            sd_q          <= s_q;
            hi_cnt_q      <= hi_cnt_d;
            lo_cnt_q      <= lo_cnt_d;
            phase_cnt_q   <= phase_cnt_d;
            valid_q       <= valid_d;
            timeout_err_q <= timeout_err_d;
            high_time_q   <= high_time_d;
            low_time_q    <= low_time_d;
            period_q      <= period_d;
        end
    end

    assign Valid      = valid_q;
    assign TimeoutErr = timeout_err_q;
    assign HighTime   = high_time_q;
    assign LowTime    = low_time_q;
    assign Period     = period_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Testbench for clk_period_meter (single-shot build): directed and random
// square waves driven synchronously to ClkIn, checked against a duration model.
module tb_clk_period_meter;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 100;

    logic             ClkIn = 1'b0;
    logic             rst;
    logic             SigIn;
    logic             Start;
    logic             Ack;
    logic             Busy;
    logic             Valid;
    logic             TimeoutErr;
    logic [CNT_W-1:0] HighTime;
    logic [CNT_W-1:0] LowTime;
    logic [CNT_W:0]   Period;

    int checks = 0;
    int errors = 0;

    clk_period_meter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .ClkIn      (ClkIn),
        .rst        (rst),
        .SigIn      (SigIn),
        .Start      (Start),
        .Ack        (Ack),
        .Busy       (Busy),
        .Valid      (Valid),
        .TimeoutErr (TimeoutErr),
        .HighTime   (HighTime),
        .LowTime    (LowTime),
        .Period     (Period)
    );

    always #5 ClkIn = ~ClkIn;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge ClkIn);
    endtask

    // Expected result from the measurement rules. The first high is driven
    // pre+1 cycles after Start; it is detected with the phase count at pre+2,
    // and an edge arriving exactly at TIMEOUT still wins.
    function automatic void model(input int pre, input int h, input int l,
                                  output int eh, output int el, output int eto);
        if (pre + 2 > int'(TIMEOUT)) begin
            eh = 0; el = 0; eto = 1;
        end else if (h > int'(TIMEOUT)) begin
            eh = int'(TIMEOUT); el = 0; eto = 1;
        end else if (l > int'(TIMEOUT)) begin
            eh = h; el = int'(TIMEOUT); eto = 1;
        end else begin
            eh = h; el = l; eto = 0;
        end
    endfunction

    // Drive pre low, h high, l low cycles then hold high; optional Start at step start_at.
    task automatic drive_wave(input int pre, input int h, input int l, input int start_at);
        for (int i = 1; i <= pre + h + l; i++) begin
            tick();
            Start = (i == start_at);
            Ack   = 1'b0;
            SigIn = (i > pre) && (i <= pre + h);
            if (i == 1) check("busy_after_start", 64'(Busy), 64'(1));
        end
        tick();
        Start = 1'b0;
        SigIn = 1'b1;
    endtask

    task automatic wait_check(input string tag, input int pre, input int h, input int l);
        int eh, el, eto;
        model(pre, h, l, eh, el, eto);
        for (int k = 0; k < 12 && Valid !== 1'b1; k++) tick();
        check({tag, "_valid"}, 64'(Valid), 64'(1));
        check({tag, "_busy"}, 64'(Busy), 64'(0));
        check({tag, "_terr"}, 64'(TimeoutErr), 64'(eto));
        check({tag, "_high"}, 64'(HighTime), 64'(eh));
        check({tag, "_low"}, 64'(LowTime), 64'(el));
        check({tag, "_period"}, 64'(Period), 64'(eh + el));
    endtask

    task automatic ack_check(input string tag, input int pre, input int h, input int l);
        int eh, el, eto;
        model(pre, h, l, eh, el, eto);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check({tag, "_ack_valid"}, 64'(Valid), 64'(0));
        check({tag, "_ack_high"}, 64'(HighTime), 64'(eh));
        check({tag, "_ack_low"}, 64'(LowTime), 64'(el));
        check({tag, "_ack_period"}, 64'(Period), 64'(eh + el));
    endtask

    task automatic run_meas(input string tag, input int pre, input int h, input int l);
        SigIn = 1'b0;
        repeat (4) tick();
        Start = 1'b1;
        drive_wave(pre, h, l, 0);
        wait_check(tag, pre, h, l);
        ack_check(tag, pre, h, l);
    endtask

    initial begin
        int cnt;
        rst   = 1'b1;
        SigIn = 1'b0;
        Start = 1'b0;
        Ack   = 1'b0;
        repeat (2) tick();
        check("rst_busy", 64'(Busy), 64'(0));
        check("rst_valid", 64'(Valid), 64'(0));
        check("rst_terr", 64'(TimeoutErr), 64'(0));
        check("rst_high", 64'(HighTime), 64'(0));
        check("rst_period", 64'(Period), 64'(0));
        rst = 1'b0;
        repeat (2) tick();

        // Ack while idle has no effect.
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        check("idle_ack_busy", 64'(Busy), 64'(0));
        check("idle_ack_valid", 64'(Valid), 64'(0));

        run_meas("sq5_5", 2, 5, 5);
        run_meas("duty3_7", 1, 3, 7);

        // Stuck-low input: timeout 101 cycles after SYNC entry.
        SigIn = 1'b0;
        repeat (4) tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        cnt = 0;
        while (Valid !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        check("stuck_latency", 64'(cnt), 64'(101));
        check("stuck_terr", 64'(TimeoutErr), 64'(1));
        check("stuck_high", 64'(HighTime), 64'(0));
        check("stuck_low", 64'(LowTime), 64'(0));
        check("stuck_period", 64'(Period), 64'(0));
        ack_check("stuck", 99, 1, 1);

        // Start mid-high, plus a stray Start during the measured high phase.
        SigIn = 1'b1;
        repeat (6) tick();
        Start = 1'b1;
        drive_wave(4, 4, 4, 8);
        check("midstart_valid_early", 64'(Valid), 64'(0));
        wait_check("midstart", 4, 4, 4);

        // Start and Ack together in DONE re-arm the meter.
        Start = 1'b1;
        Ack   = 1'b1;
        SigIn = 1'b0;
        tick();
        Start = 1'b0;
        Ack   = 1'b0;
        check("rearm_busy", 64'(Busy), 64'(1));
        check("rearm_valid", 64'(Valid), 64'(0));
        check("rearm_terr", 64'(TimeoutErr), 64'(0));
        drive_wave(3, 5, 3, 0);
        wait_check("rearm", 3, 5, 3);
        ack_check("rearm", 3, 5, 3);

        // Asynchronous reset while in HIGH.
        SigIn = 1'b0;
        repeat (4) tick();
        Start = 1'b1;
        tick();
        Start = 1'b0;
        repeat (2) tick();
        SigIn = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        #1;
        check("midrst_busy", 64'(Busy), 64'(0));
        check("midrst_valid", 64'(Valid), 64'(0));
        check("midrst_high", 64'(HighTime), 64'(0));
        check("midrst_low", 64'(LowTime), 64'(0));
        check("midrst_period", 64'(Period), 64'(0));
        repeat (2) tick();
        rst = 1'b0;
        run_meas("post_rst", 2, 6, 2);

        // Timeout boundaries: edge at the limit wins, one past the limit aborts.
        run_meas("high_at_limit", 0, 100, 1);
        run_meas("high_over", 0, 101, 3);
        run_meas("low_over", 2, 5, 101);
        run_meas("sync_at_limit", 98, 2, 2);
        run_meas("sync_over", 99, 2, 2);
        run_meas("min_1_1", 0, 1, 1);

        for (int n = 0; n < 10; n++) begin
            run_meas("rand", int'($urandom_range(0, 6)), int'($urandom_range(1, 40)),
                     int'($urandom_range(1, 40)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
